// File: rtl/lcd_test.sv
// lcd_test: keypad plaintext-entry buffer with 2x16 HD44780 refresh driver; define LCD_CURSOR_EN for cursor display and parking
module lcd_test #(
    parameter int TICK_DIV  = 1,
    parameter int INIT_WAIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [11:0] Keypad,
    output logic [7:0]  LCD_DATA,
    output logic        LCD_E,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic [7:0]  Out_PlainText1,
    output logic [7:0]  Out_PlainText2,
    output logic [7:0]  Out_PlainText3,
    output logic [7:0]  Out_PlainText4,
    output logic [7:0]  Out_PlainText5,
    output logic [7:0]  Out_PlainText6,
    output logic [7:0]  Out_PlainText7,
    output logic [7:0]  Out_PlainText8,
    output logic [7:0]  Out_PlainText9,
    output logic [7:0]  Out_PlainText10,
    output logic [7:0]  Out_PlainText11,
    output logic [7:0]  Out_PlainText12,
    output logic [7:0]  Out_PlainText13,
    output logic [7:0]  Out_PlainText14,
    output logic [7:0]  Out_PlainText15,
    output logic [7:0]  Out_PlainText16,
    output logic        CHK
);
    typedef enum logic [3:0] {
        DELAY, FUNC_SET, DISP_ON, ENTRY_MODE, CLEAR,
        LINE1_ADDR, LINE1_DATA, CURSOR, LINE2_ADDR, LINE2_DATA
    } lcdState_e;

    localparam logic [127:0] MSG_WAIT  = "INPUT PLAINTEXT ";
    localparam logic [127:0] MSG_READY = "PLAINTEXT READY ";
`ifdef LCD_CURSOR_EN
    localparam logic [7:0] DISP_CMD = 8'h0F;
`else
    localparam logic [7:0] DISP_CMD = 8'h0C;
`endif

    logic [11:0]  keyQ;
    logic         pressValid;
    logic [3:0]   pressKey, keyIdx;
    logic [7:0]   slot [16];
    logic [4:0]   count;
    logic [15:0]  tickCnt, cnt, cntN;
    logic         tick, phase, phaseN, eN, rsN, isData, last;
    logic [7:0]   cmd, dataN;
    logic [127:0] msg;
    lcdState_e    state, stateN, after;

    assign LCD_RW = 1'b0;
    assign tick = tickCnt == 16'(TICK_DIV - 1);
    assign {Out_PlainText1, Out_PlainText2, Out_PlainText3, Out_PlainText4} = {slot[0], slot[1], slot[2], slot[3]};
    assign {Out_PlainText5, Out_PlainText6, Out_PlainText7, Out_PlainText8} = {slot[4], slot[5], slot[6], slot[7]};
    assign {Out_PlainText9, Out_PlainText10, Out_PlainText11, Out_PlainText12} = {slot[8], slot[9], slot[10], slot[11]};
    assign {Out_PlainText13, Out_PlainText14, Out_PlainText15, Out_PlainText16} = {slot[12], slot[13], slot[14], slot[15]};

    // Encode the keypad lines into a key index (only meaningful when one-hot)
    always_comb begin
        keyIdx = 4'd0;
        for (int i = 0; i < 12; i++) if (Keypad[i]) keyIdx = 4'(i);
    end

    // Register keypad and flag a press on an idle-to-one-hot transition
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            keyQ       <= '0;
            pressValid <= 1'b0;
            pressKey   <= '0;
        end else begin
            keyQ       <= Keypad;
            pressValid <= keyQ == 12'd0 && $onehot(Keypad);
            pressKey   <= keyIdx;
        end
    end

    // Apply accepted presses to the plaintext buffer; CHK tracks a full buffer
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) slot[i] <= 8'h20;
            count <= '0;
            CHK   <= 1'b0;
        end else if (pressValid) begin
            if (pressKey < 4'd10 && count != 5'd16) begin
                slot[count[3:0]] <= 8'h30 + {4'h0, pressKey};
                count <= count + 5'd1;
                CHK   <= count == 5'd15;
            end else if (pressKey == 4'd10 && count != 5'd0) begin
                slot[4'(count - 5'd1)] <= 8'h20;
                count <= count - 5'd1;
                CHK   <= 1'b0;
            end else if (pressKey == 4'd11) begin
                for (int i = 0; i < 16; i++) slot[i] <= 8'h20;
                count <= '0;
                CHK   <= 1'b0;
            end
        end
    end

    // LCD sequencer: pick byte for the current state, then step A raises E, step B drops it and advances
    always_comb begin
        cmd    = 8'h00;
        isData = 1'b0;
        after  = state;
        last   = 1'b0;
        msg    = CHK ? MSG_READY : MSG_WAIT;
        case (state)
            FUNC_SET:   begin cmd = 8'h38;    after = DISP_ON;    end
            DISP_ON:    begin cmd = DISP_CMD; after = ENTRY_MODE; end
            ENTRY_MODE: begin cmd = 8'h06;    after = CLEAR;      end
            CLEAR:      begin cmd = 8'h01;    after = LINE1_ADDR; end
            LINE1_ADDR: begin cmd = 8'h80;    after = LINE1_DATA; end
            LINE1_DATA: begin
                cmd    = slot[cnt[3:0]];
                isData = 1'b1;
`ifdef LCD_CURSOR_EN
                after  = CURSOR;
`else
                after  = LINE2_ADDR;
`endif
            end
            CURSOR:     begin cmd = 8'h80 | {4'h0, count[4] ? 4'hF : count[3:0]}; after = LINE2_ADDR; end
            LINE2_ADDR: begin cmd = 8'hC0;    after = LINE2_DATA; end
            LINE2_DATA: begin
                cmd    = 8'(msg >> {~cnt[3:0], 3'b000});
                isData = 1'b1;
                after  = LINE1_ADDR;
            end
            default:    begin cmd = 8'h00;    after = FUNC_SET;   end
        endcase
        stateN = state;
        phaseN = phase;
        cntN   = cnt;
        eN     = LCD_E;
        rsN    = LCD_RS;
        dataN  = LCD_DATA;
        if (state == DELAY) begin
            eN     = 1'b0;
            last   = cnt == 16'(INIT_WAIT - 1);
            stateN = last ? FUNC_SET : DELAY;
            cntN   = last ? 16'd0 : cnt + 16'd1;
        end else if (!phase) begin
            eN     = 1'b1;
            rsN    = isData;
            dataN  = cmd;
            phaseN = 1'b1;
        end else begin
            eN     = 1'b0;
            phaseN = 1'b0;
            last   = !isData || cnt == 16'd15;
            stateN = last ? after : state;
            cntN   = last ? 16'd0 : cnt + 16'd1;
        end
    end

    // LCD state and bus registers, advanced once per tick
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tickCnt  <= '0;
            state    <= DELAY;
            phase    <= 1'b0;
            cnt      <= '0;
            LCD_E    <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_DATA <= 8'h00;
        end else begin
            tickCnt <= tick ? 16'd0 : tickCnt + 16'd1;
            if (tick) begin
                state    <= stateN;
                phase    <= phaseN;
                cnt      <= cntN;
                LCD_E    <= eN;
                LCD_RS   <= rsN;
                LCD_DATA <= dataN;
            end
        end
    end
endmodule

// File: tb/tb_lcd_test.sv
// tb_lcd_test: directed scoreboard bench for the keypad buffer and LCD refresh driver
module tb_lcd_test;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [11:0] Keypad = '0;
    logic [7:0]  LCD_DATA;
    logic        LCD_E, LCD_RS, LCD_RW, CHK;
    logic [7:0]  pt [16];
    int          checks = 0;
    int          errors = 0;
    logic [8:0]  expQ [$];
    bit          synced = 1'b0;
    logic        prevE = 1'b0;
    logic [7:0]  es [16];
    int          ecnt = 0;

    lcd_test dut (
        .CLK(CLK), .RST(RST), .Keypad(Keypad),
        .LCD_DATA(LCD_DATA), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .Out_PlainText1(pt[0]),   .Out_PlainText2(pt[1]),   .Out_PlainText3(pt[2]),   .Out_PlainText4(pt[3]),
        .Out_PlainText5(pt[4]),   .Out_PlainText6(pt[5]),   .Out_PlainText7(pt[6]),   .Out_PlainText8(pt[7]),
        .Out_PlainText9(pt[8]),   .Out_PlainText10(pt[9]),  .Out_PlainText11(pt[10]), .Out_PlainText12(pt[11]),
        .Out_PlainText13(pt[12]), .Out_PlainText14(pt[13]), .Out_PlainText15(pt[14]), .Out_PlainText16(pt[15]),
        .CHK(CHK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input int k);
        if (k < 10 && ecnt < 16) begin
            es[ecnt] = 8'h30 + 8'(k);
            ecnt++;
        end else if (k == 10 && ecnt > 0) begin
            ecnt--;
            es[ecnt] = 8'h20;
        end else if (k == 11) begin
            for (int i = 0; i < 16; i++) es[i] = 8'h20;
            ecnt = 0;
        end
    endtask

    task automatic press(input int k, input int hold);
        @(negedge CLK);
        Keypad = 12'(1 << k);
        repeat (hold) @(negedge CLK);
        Keypad = '0;
        repeat (3) @(negedge CLK);
        model(k);
    endtask

    task automatic checkBuf(input string tag);
        for (int i = 0; i < 16; i++) chk($sformatf("%s_slot%0d", tag, i + 1), {1'b0, pt[i]}, {1'b0, es[i]});
        chk({tag, "_chk"}, {8'h00, CHK}, {8'h00, ecnt == 16});
    endtask

    task automatic pushPass();
        string m;
        m = (ecnt == 16) ? "PLAINTEXT READY " : "INPUT PLAINTEXT ";
        expQ.push_back(9'h080);
        for (int i = 0; i < 16; i++) expQ.push_back({1'b1, es[i]});
        expQ.push_back(9'h0C0);
        for (int i = 0; i < 16; i++) expQ.push_back({1'b1, m[i]});
        expQ.push_back(9'h080);
    endtask

    task automatic pushInit();
        expQ.push_back(9'h038);
        expQ.push_back(9'h00C);
        expQ.push_back(9'h006);
        expQ.push_back(9'h001);
        expQ.push_back(9'h080);
    endtask

    task automatic waitDrain(input string tag, input int lim);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < lim) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        assert (expQ.size() == 0) else begin
            errors++;
            $error("FAIL %s_drain observed_left=%0d expected_left=0", tag, expQ.size());
            expQ.delete();
        end
        synced = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) es[i] = 8'h20;
        fork
            forever begin
                @(negedge CLK);
                if (prevE && !LCD_E && expQ.size() != 0) begin
                    if (!synced) begin
                        if ({LCD_RS, LCD_DATA} === expQ[0]) begin
                            void'(expQ.pop_front());
                            synced = 1'b1;
                        end
                    end else chk("lcd_xfer", {LCD_RS, LCD_DATA}, expQ.pop_front());
                    if (expQ.size() == 0) synced = 1'b0;
                end
                prevE = LCD_E;
            end
        join_none
        repeat (2) @(negedge CLK);
        checkBuf("reset");
        chk("reset_e", {8'h00, LCD_E}, 9'h000);
        chk("reset_rw", {8'h00, LCD_RW}, 9'h000);
        chk("reset_bus", {LCD_RS, LCD_DATA}, 9'h000);
        synced = 1'b1;
        pushInit();
        for (int i = 0; i < 16; i++) expQ.push_back(9'h120);
        begin
            string m;
            m = "INPUT PLAINTEXT ";
            expQ.push_back(9'h0C0);
            for (int i = 0; i < 16; i++) expQ.push_back({1'b1, m[i]});
            expQ.push_back(9'h080);
        end
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk($sformatf("delay_e%0d", i), {8'h00, LCD_E}, 9'h000);
        end
        @(negedge CLK);
        chk("first_strobe", {LCD_E, LCD_DATA}, 9'h138);
        waitDrain("init", 200);
        @(negedge CLK);
        Keypad = 12'h001;
        @(negedge CLK);
        chk("lat_before", {1'b0, pt[0]}, 9'h020);
        @(negedge CLK);
        chk("lat_after", {1'b0, pt[0]}, 9'h030);
        repeat (2) @(negedge CLK);
        Keypad = '0;
        repeat (3) @(negedge CLK);
        model(0);
        checkBuf("hold1");
        press(4, 4);
        press(8, 4);
        checkBuf("three");
        press(5, 2);
        checkBuf("four");
        press(10, 2);
        checkBuf("bksp");
        press(6, 1);
        checkBuf("after_bksp");
        pushPass();
        waitDrain("pass_partial", 300);
        @(negedge CLK);
        Keypad = 12'h011;
        repeat (3) @(negedge CLK);
        Keypad = 12'h001;
        repeat (3) @(negedge CLK);
        Keypad = '0;
        repeat (3) @(negedge CLK);
        checkBuf("multibit");
        press(1, 1);
        checkBuf("five");
        press(11, 2);
        checkBuf("clear");
        for (int i = 0; i < 17; i++) begin
            press(i % 10, 1);
            if (i == 15) checkBuf("full16");
        end
        checkBuf("full17");
        pushPass();
        waitDrain("pass_ready", 300);
        press(10, 1);
        checkBuf("bksp_full");
        repeat (7) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("midreset_e", {8'h00, LCD_E}, 9'h000);
        chk("midreset_bus", {LCD_RS, LCD_DATA}, 9'h000);
        for (int i = 0; i < 16; i++) es[i] = 8'h20;
        ecnt = 0;
        checkBuf("midreset");
        @(negedge CLK);
        synced = 1'b1;
        pushInit();
        RST = 1'b1;
        waitDrain("reinit", 200);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
